// File: rtl/uart_ctrl_pkg.sv
// rtl/uart_ctrl_pkg.sv - register offsets, CON bit indices and TX FSM states for uart_mmio_ctrl
package uart_ctrl_pkg;

    localparam logic [31:0] TXD_OFS = 32'h0;
    localparam logic [31:0] RXD_OFS = 32'h4;
    localparam logic [31:0] CON_OFS = 32'h8;

    localparam int CON_RX_FULL   = 0;
    localparam int CON_TX_EMPTY  = 1;
    localparam int CON_TX_FULL   = 2;
    localparam int CON_TX_ACTIVE = 3;
    localparam int CON_RX_OVR    = 4;
    localparam int CON_TX_OVF    = 5;
    localparam int CON_IRQ_RX_EN = 6;
    localparam int CON_IRQ_TX_EN = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_WAIT_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding the UART transmitter
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data     enqueue a byte; ignored when full
//   pop                 dequeue the head; ignored when empty
//   head                current head byte
//   empty, full         occupancy flags derived from the occupancy counter
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       empty,
    output logic       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push_ok;
    logic          pop_ok;

    // Flags come from the pre-edge count, so a push into a full FIFO is
    // rejected even if the head is popped in the same cycle.
    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// rtl/uart_mmio_ctrl.sv - memory-mapped UART controller (TXD/RXD/CON registers, TX FIFO, TX launch FSM)
//
// Optional feature macro: UART_CTRL_IRQ_EN (stores CON[7:6] and drives irq).
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   addr, MemRead, MemWrite    CPU byte address and access strobes
//   wdata, rdata               write data, combinational read data
//   rx_data, rx_valid          received byte with one-cycle valid pulse
//   tx_data, tx_start, tx_busy byte to transmitter, launch pulse, transmitter busy
//   irq                        level interrupt request
module uart_mmio_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE     = 32'h4000_0018,
    parameter int          TX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        irq
);

    logic       sel_txd, sel_rxd, sel_con;
    logic       wr_txd, wr_con, rd_rxd;
    logic [7:0] rxd, last_tx, fifo_head, con;
    logic       rx_full, rx_ovr, tx_ovf;
    logic       fifo_empty, fifo_full, tx_active;
    logic       irq_rx_en, irq_tx_en;
    tx_state_t  state, state_next;

    assign sel_txd = (addr == BASE + TXD_OFS);
    assign sel_rxd = (addr == BASE + RXD_OFS);
    assign sel_con = (addr == BASE + CON_OFS);
    assign wr_txd  = MemWrite && sel_txd;
    assign wr_con  = MemWrite && sel_con;
    assign rd_rxd  = MemRead && sel_rxd;

    uart_tx_fifo #(.DEPTH(TX_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_txd),
        .push_data (wdata[7:0]),
        .pop       (tx_start),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (!fifo_empty && !tx_busy) state_next = ST_START;
            ST_START:   state_next = ST_WAIT_HI;
            ST_WAIT_HI: if (tx_busy) state_next = ST_WAIT_LO;
            ST_WAIT_LO: if (!tx_busy) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    assign tx_start  = (state == ST_START);
    assign tx_active = (state != ST_IDLE);
    assign tx_data   = tx_start ? fifo_head : last_tx;

    // A new byte arriving in the same cycle as an RXD read wins: the read
    // consumed the old byte, so rx_full stays set and no overrun is flagged.
    // Overrun/overflow sets take priority over a simultaneous W1C clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd     <= 8'h0;
            rx_full <= 1'b0;
            rx_ovr  <= 1'b0;
            tx_ovf  <= 1'b0;
            last_tx <= 8'h0;
        end else begin
            if (rx_valid) begin
                rxd     <= rx_data;
                rx_full <= 1'b1;
            end else if (rd_rxd) begin
                rx_full <= 1'b0;
            end

            if (rx_valid && rx_full && !rd_rxd) rx_ovr <= 1'b1;
            else if (wr_con && wdata[CON_RX_OVR]) rx_ovr <= 1'b0;

            if (wr_txd && fifo_full) tx_ovf <= 1'b1;
            else if (wr_con && wdata[CON_TX_OVF]) tx_ovf <= 1'b0;

            if (tx_start) last_tx <= fifo_head;
        end
    end

`ifdef UART_CTRL_IRQ_EN
    logic unused_wdata;
    assign unused_wdata = ^wdata[31:8];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_rx_en <= 1'b0;
            irq_tx_en <= 1'b0;
        end else if (wr_con) begin
            irq_rx_en <= wdata[CON_IRQ_RX_EN];
            irq_tx_en <= wdata[CON_IRQ_TX_EN];
        end
    end

    assign irq = (irq_rx_en && rx_full) || (irq_tx_en && fifo_empty && !tx_active);
`else
    logic unused_wdata;
    assign unused_wdata = ^{wdata[31:8], wdata[7:6]};
    assign irq_rx_en    = 1'b0;
    assign irq_tx_en    = 1'b0;
    assign irq          = 1'b0;
`endif

    assign con = {irq_tx_en, irq_rx_en, tx_ovf, rx_ovr,
                  tx_active, fifo_full, fifo_empty, rx_full};

    // Read data is forced to zero while reset is held low.
    always_comb begin
        rdata = 32'h0;
        if (reset && MemRead) begin
            if (sel_rxd)      rdata = {24'h0, rxd};
            else if (sel_con) rdata = {24'h0, con};
        end
    end

endmodule

// File: doc/uart_mmio_ctrl.md
UART_MMIO_CTRL -- requirements
Module: uart_mmio_ctrl

Interface
REQ-001 Parameter BASE, default 32'h4000_0018, byte address of TXD; RXD = BASE+4; CON = BASE+8.
REQ-002 Parameter TX_DEPTH, default 4, TX FIFO entries (power of two, 2..16).
REQ-003 clk  in  1  system clock, single clock domain; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 addr  in  32  CPU byte address; MemRead  in  1  read strobe; MemWrite  in  1  write strobe.
REQ-006 wdata  in  32  write data; rdata  out  32  read data, combinational.
REQ-007 rx_data  in  8  received byte; rx_valid  in  1  one-cycle pulse, byte valid.
REQ-008 tx_data  out  8  byte to send; tx_start  out  1  one-cycle launch pulse; tx_busy  in  1  transmitter busy.
REQ-009 irq  out  1  level interrupt request.

Function
REQ-010 rdata SHALL be the addressed register when MemRead and addr matches TXD/RXD/CON, else 32'h0; read latency 0 cycles.
REQ-011 TXD read SHALL return 0; RXD read returns {24'h0, rxd}; CON read returns {24'h0, con[7:0]}.
REQ-012 CON bits: [0] rx_full, [1] tx_empty, [2] tx_full, [3] tx_active, [4] rx_ovr, [5] tx_ovf, [6] irq_rx_en, [7] irq_tx_en.
REQ-013 MemWrite to TXD with tx_full=0 SHALL push wdata[7:0] at the edge; with tx_full=0 determined by pre-edge count, even if a pop occurs that cycle.
REQ-014 MemWrite to TXD with tx_full=1 SHALL drop the byte and set tx_ovf.
REQ-015 MemWrite to CON SHALL load bits 7:6; writing 1 to bit 4 or 5 SHALL clear rx_ovr or tx_ovf (W1C); other bits read-only.
REQ-016 rx_valid SHALL load rxd and set rx_full; if rx_full already 1 and no RXD read that cycle, rx_ovr SHALL also set.
REQ-017 MemRead of RXD SHALL clear rx_full at the edge; simultaneous rx_valid wins: rxd updated, rx_full stays 1, no overrun.
REQ-018 TX FSM states IDLE, START, WAIT_HI, WAIT_LO; tx_active = (state != IDLE).
REQ-019 IDLE -> START when FIFO non-empty and tx_busy=0.
REQ-020 START: tx_start=1 for exactly one cycle, tx_data = FIFO head, head popped at edge; -> WAIT_HI.
REQ-021 WAIT_HI -> WAIT_LO when tx_busy=1; WAIT_LO -> IDLE when tx_busy=0.
REQ-022 tx_data SHALL hold the last launched byte outside START.
REQ-023 FIFO SHALL wrap pointers modulo TX_DEPTH; tx_empty/tx_full derived from an occupancy counter 0..TX_DEPTH.
REQ-024 Back-to-back bytes SHALL be launched with minimum 1 IDLE cycle between tx_busy falling and next tx_start.

Reset
REQ-025 On reset low: FSM IDLE, FIFO empty, rxd=0, all CON bits 0 except tx_empty=1.
REQ-026 Outputs during reset: rdata=0, tx_data=0, tx_start=0, irq=0.
REQ-027 Reset asserted mid-transmission SHALL discard FIFO contents and abort FSM; no tx_start after release until a new push.

Configuration
REQ-028 Macro UART_CTRL_IRQ_EN defined: irq = (irq_rx_en & rx_full) | (irq_tx_en & tx_empty & ~tx_active).
REQ-029 Macro undefined: irq tied 0, CON bits 7:6 not stored and read 0, writes ignored.

Structure
REQ-030 Package uart_ctrl_pkg SHALL hold register offsets, CON bit indices, and the TX FSM state enum.
REQ-031 Sub-module uart_tx_fifo (parameter DEPTH) SHALL implement storage, pointers and occupancy; FSM and registers stay in uart_mmio_ctrl.

Verification
REQ-032 rx_valid with rx_data=8'h54 -> CON[0]=1; RXD read returns 32'h54; next cycle CON[0]=0.
REQ-033 Two rx_valid (8'h54, 8'h0C) without read -> rxd=8'h0C, CON[4]=1; write CON 32'h10 -> CON[4]=0.
REQ-034 Write TXD 8'h60, tx_busy high 3 cycles after START -> single tx_start pulse with tx_data=8'h60, FSM back to IDLE, CON[1]=1.
REQ-035 Five TXD writes (8'h01..8'h05) with tx_busy held 1 -> four stored, CON[2]=1, CON[5]=1; released bytes appear in order 01..04.
REQ-036 UART_CTRL_IRQ_EN defined, CON=32'hC0, empty idle -> irq=1; push byte -> irq=0 until transmission done.
REQ-037 Reset low during WAIT_LO with 2 bytes queued -> after release CON=32'h02, no tx_start observed for 100 cycles.
